// File: rtl/logic_gates.sv
// Bitwise AND/OR/XOR unit with a LATENCY-deep registered pipeline and valid flag.
// Optional macro LOGIC_GATES_INV_EN adds NAND/NOR/XNOR outputs y3..y5.
module logic_gates #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
`ifdef LOGIC_GATES_INV_EN
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
`endif
    output logic             valid
);

`ifdef LOGIC_GATES_INV_EN
    localparam int NRES = 6;
`else
    localparam int NRES = 3;
`endif
    localparam int RW = NRES * WIDTH;

    generate
        if (LATENCY < 0 || LATENCY > 4 || WIDTH < 1) begin : g_bad_param
            $error("logic_gates: WIDTH must be >= 1 and LATENCY must be 0..4");
        end
    endgenerate

    // Results are packed with y0 in the most significant field.
    function automatic logic [RW-1:0] gate_eval(input logic [WIDTH-1:0] ia,
                                                input logic [WIDTH-1:0] ib);
`ifdef LOGIC_GATES_INV_EN
        return {ia & ib, ia | ib, ia ^ ib, ~(ia & ib), ~(ia | ib), ~(ia ^ ib)};
`else
        return {ia & ib, ia | ib, ia ^ ib};
`endif
    endfunction

    logic [RW-1:0] res_comb;
    logic [RW-1:0] res_out;
    logic          vld_out;

    assign res_comb = gate_eval(a, b);

    generate
        if (LATENCY == 0) begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign res_out = res_comb;
            assign vld_out = en;
        end else begin : g_pipe
            logic [RW-1:0] data_p [LATENCY];
            logic          vld_p  [LATENCY];

            // Stage 1 loads every edge; valid carries en. Later stages shift.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < LATENCY; k++) begin
                        data_p[k] <= '0;
                        vld_p[k]  <= 1'b0;
                    end
                end else begin
                    data_p[0] <= res_comb;
                    vld_p[0]  <= en;
                    for (int k = 1; k < LATENCY; k++) begin
                        data_p[k] <= data_p[k-1];
                        vld_p[k]  <= vld_p[k-1];
                    end
                end
            end

            assign res_out = data_p[LATENCY-1];
            assign vld_out = vld_p[LATENCY-1];
        end
    endgenerate

`ifdef LOGIC_GATES_INV_EN
    assign {y0, y1, y2, y3, y4, y5} = res_out;
`else
    assign {y0, y1, y2} = res_out;
`endif
    assign valid = vld_out;

endmodule

// File: tb/tb_logic_gates.sv
// Bench for logic_gates: three configurations checked against a sample-history model.
module tb_logic_gates;

    logic clk = 1'b0;
    logic clk_run = 1'b1;
    logic rst = 1'b1;

    // WIDTH=1 LATENCY=1
    logic       a1 = 1'b0, b1 = 1'b0, en1 = 1'b0;
    logic       y0_1, y1_1, y2_1, valid1;
    // WIDTH=8 LATENCY=3
    logic [7:0] a3 = '0, b3 = '0;
    logic       en3 = 1'b0;
    logic [7:0] y0_3, y1_3, y2_3;
    logic       valid3;
    // WIDTH=8 LATENCY=0
    logic [7:0] a0 = '0, b0 = '0;
    logic       en0 = 1'b0;
    logic [7:0] y0_0, y1_0, y2_0;
    logic       valid0;
`ifdef LOGIC_GATES_INV_EN
    logic       y3_1, y4_1, y5_1;
    logic [7:0] y3_3, y4_3, y5_3, y3_0, y4_0, y5_0;
`endif

    int n_total = 0;
    int n_pass  = 0;
    logic chk_on = 1'b0;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    logic_gates #(.WIDTH(1), .LATENCY(1)) u_w1l1 (
        .clk(clk), .rst(rst), .en(en1), .a(a1), .b(b1),
        .y0(y0_1), .y1(y1_1), .y2(y2_1),
`ifdef LOGIC_GATES_INV_EN
        .y3(y3_1), .y4(y4_1), .y5(y5_1),
`endif
        .valid(valid1));

    logic_gates #(.WIDTH(8), .LATENCY(3)) u_w8l3 (
        .clk(clk), .rst(rst), .en(en3), .a(a3), .b(b3),
        .y0(y0_3), .y1(y1_3), .y2(y2_3),
`ifdef LOGIC_GATES_INV_EN
        .y3(y3_3), .y4(y4_3), .y5(y5_3),
`endif
        .valid(valid3));

    logic_gates #(.WIDTH(8), .LATENCY(0)) u_w8l0 (
        .clk(clk), .rst(rst), .en(en0), .a(a0), .b(b0),
        .y0(y0_0), .y1(y1_0), .y2(y2_0),
`ifdef LOGIC_GATES_INV_EN
        .y3(y3_0), .y4(y4_0), .y5(y5_0),
`endif
        .valid(valid0));

    // Model: remember what was sampled at each of the last N edges; a reset
    // forgets everything. Outputs are the spec's gate rules on the oldest sample.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       en;
        logic       live;
    } samp_t;

    samp_t h1;
    samp_t h3 [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h1 <= '0;
            for (int i = 0; i < 3; i++) h3[i] <= '0;
        end else begin
            h1    <= '{a: {7'b0, a1}, b: {7'b0, b1}, en: en1, live: 1'b1};
            h3[0] <= '{a: a3, b: b3, en: en3, live: 1'b1};
            h3[1] <= h3[0];
            h3[2] <= h3[1];
        end
    end

    // {valid, y0, y1, y2, y3, y4, y5}; y3..y5 stay 0 when the macro is off.
    function automatic logic [48:0] ref_out(input samp_t s, input logic [7:0] m);
        logic [48:0] r;
        r = '0;
        if (s.live) begin
            r[48]    = s.en;
            r[47:40] = (s.a & s.b) & m;
            r[39:32] = (s.a | s.b) & m;
            r[31:24] = (s.a ^ s.b) & m;
`ifdef LOGIC_GATES_INV_EN
            r[23:16] = ~(s.a & s.b) & m;
            r[15:8]  = ~(s.a | s.b) & m;
            r[7:0]   = ~(s.a ^ s.b) & m;
`endif
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [48:0] act1();
        logic [48:0] r;
        r = '0;
        r[48] = valid1; r[40] = y0_1; r[32] = y1_1; r[24] = y2_1;
`ifdef LOGIC_GATES_INV_EN
        r[16] = y3_1; r[8] = y4_1; r[0] = y5_1;
`endif
        return r;
    endfunction

    function automatic logic [48:0] act3();
        logic [48:0] r;
        r = {valid3, y0_3, y1_3, y2_3, 24'h0};
`ifdef LOGIC_GATES_INV_EN
        r[23:0] = {y3_3, y4_3, y5_3};
`endif
        return r;
    endfunction

    function automatic logic [48:0] act0();
        logic [48:0] r;
        r = {valid0, y0_0, y1_0, y2_0, 24'h0};
`ifdef LOGIC_GATES_INV_EN
        r[23:0] = {y3_0, y4_0, y5_0};
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_w1l1", {15'h0, act1()}, {15'h0, ref_out(h1, 8'h01)});
            chk("model_w8l3", {15'h0, act3()}, {15'h0, ref_out(h3[2], 8'hFF)});
            chk("model_w8l0", {15'h0, act0()},
                {15'h0, ref_out('{a: a0, b: b0, en: en0, live: 1'b1}, 8'hFF)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_w1 [4];

    initial begin
        exp_w1[0] = 3'b000; exp_w1[1] = 3'b011; exp_w1[2] = 3'b011; exp_w1[3] = 3'b110;

        repeat (2) step();
        chk("rst_y0_l3", {56'h0, y0_3}, 64'h0);
        chk("rst_valid_l3", {63'h0, valid3}, 64'h0);
        chk("rst_y_l1", {61'h0, y0_1, y1_1, y2_1}, 64'h0);
`ifdef LOGIC_GATES_INV_EN
        chk("rst_inv_l3", {40'h0, y3_3, y4_3, y5_3}, 64'h0);
`endif
        rst = 1'b0;
        chk_on = 1'b1;

        // Truth table through one register stage.
        en1 = 1'b1;
        for (int v = 0; v < 4; v++) begin
            a1 = v[1];
            b1 = v[0];
            step();
            chk($sformatf("w1_ab%0d", v), {61'h0, y0_1, y1_1, y2_1}, {61'h0, exp_w1[v]});
            chk($sformatf("w1_valid%0d", v), {63'h0, valid1}, 64'h1);
        end

        // Single-cycle pulse through three stages with the 8-bit vector.
        a3 = 8'hF0; b3 = 8'h3C; en3 = 1'b1;
        step();
        a3 = 8'h00; b3 = 8'h00; en3 = 1'b0;
        step();
        chk("l3_valid_early", {63'h0, valid3}, 64'h0);
        step();
        chk("l3_vec", {39'h0, valid3, y0_3, y1_3, y2_3}, {39'h0, 1'b1, 8'h30, 8'hFC, 8'hCC});
`ifdef LOGIC_GATES_INV_EN
        chk("l3_vec_inv", {40'h0, y3_3, y4_3, y5_3}, {40'h0, 8'hCF, 8'h03, 8'h33});
`endif
        step();
        chk("l3_valid_after", {63'h0, valid3}, 64'h0);

        a3 = 8'h01; b3 = 8'h01; en3 = 1'b1;
        step();
        en3 = 1'b0; a3 = 8'h00; b3 = 8'h00;
        repeat (2) step();
        chk("l3_pulse", {55'h0, valid3, y0_3}, {55'h0, 1'b1, 8'h01});
        step();
        chk("l3_pulse_end", {63'h0, valid3}, 64'h0);

        // Asynchronous reset between edges while results are in flight.
        a1 = 1'b1; b1 = 1'b1; en1 = 1'b1;
        a3 = 8'h01; b3 = 8'h01; en3 = 1'b1;
        repeat (3) step();
        chk("pre_rst_valid", {62'h0, valid3, valid1}, 64'h3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_l3", {39'h0, valid3, y0_3, y1_3, y2_3}, 64'h0);
        chk("async_rst_l1", {60'h0, valid1, y0_1, y1_1, y2_1}, 64'h0);
        #3 rst = 1'b0;
        a1 = 1'b1; b1 = 1'b0;
        a3 = 8'h01; b3 = 8'h00;
        step();
        chk("post_rst_l1", {62'h0, y1_1, y2_1}, 64'h3);
        chk("post_rst_l3_flushed", {63'h0, valid3}, 64'h0);
        repeat (2) step();
        chk("post_rst_l3", {47'h0, valid3, y1_3, y2_3}, {47'h0, 1'b1, 8'h01, 8'h01});

        // Combinational configuration with the clock stopped.
        clk_run = 1'b0;
        a0 = 8'hF0; b0 = 8'h3C; en0 = 1'b1;
        #1;
        chk("l0_vec", {39'h0, valid0, y0_0, y1_0, y2_0}, {39'h0, 1'b1, 8'h30, 8'hFC, 8'hCC});
`ifdef LOGIC_GATES_INV_EN
        chk("l0_vec_inv", {40'h0, y3_0, y4_0, y5_0}, {40'h0, 8'hCF, 8'h03, 8'h33});
`endif
        en0 = 1'b0;
        #1;
        chk("l0_en_low", {63'h0, valid0}, 64'h0);
        a0 = 8'hAA; b0 = 8'h55; en0 = 1'b1;
        #1;
        chk("l0_toggle", {39'h0, valid0, y0_0, y1_0, y2_0}, {39'h0, 1'b1, 8'h00, 8'hFF, 8'hFF});
        rst = 1'b1;
        #1;
        chk("l0_ignores_rst", {56'h0, y1_0}, 64'hFF);
        rst = 1'b0;
        clk_run = 1'b1;

        // Short free run with varied operands for the model compare.
        for (int i = 0; i < 20; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); en1 = 1'($urandom);
            a3 = 8'($urandom); b3 = 8'($urandom); en3 = 1'($urandom);
            a0 = 8'($urandom); b0 = 8'($urandom); en0 = 1'($urandom);
            step();
        end
        chk_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
